sram_req_adapter: RTL and testbench

SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_rsp_fifo.sv | 70 +++++++
 rtl/sram_req_adapter.sv | 141 ++++++++++++++
 tb/tb_sram_req_adapter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM request adapter and its response FIFO.
package sram_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 128;
  localparam int DEFAULT_ADDRESS_WIDTH = 7;
  localparam int DEFAULT_READ_LATENCY  = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small circular FIFO that holds read data returning from the SRAM until the requester takes it.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_READ_LATENCY + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int                 PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]   LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && (!full || do_pop);

  // NOTE: every variable assigned here gets its hold value first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; whether an entry is meaningful is tracked by count_q alone.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a byte-enabled single-port SRAM with credit-limited, in-order reads.
// Defining SRAM_REQ_ADAPTER_INIT_EN adds a power-up zero-fill of the whole SRAM before traffic.
module sram_req_adapter
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int READ_LATENCY  = DEFAULT_READ_LATENCY
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_req_address,
  input  logic [DATA_WIDTH-1:0]     i_req_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_req_byte_enable,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_read_data,
  output logic                      o_sram_write_enable,
  output logic [ADDRESS_WIDTH-1:0]  o_sram_address,
  output logic [DATA_WIDTH-1:0]     o_sram_write_data,
  output logic [DATA_WIDTH/8-1:0]   o_sram_byte_enable,
  input  logic [DATA_WIDTH-1:0]     i_sram_read_data,
  output logic                      o_init_done
);

  localparam int FIFO_DEPTH = READ_LATENCY + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic                     run;
  logic                     init_wr;
  logic [ADDRESS_WIDTH-1:0] init_addr;
  logic                     req_fire;
  logic                     rsp_pop;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [READ_LATENCY-1:0]  rd_pipe_q, rd_pipe_d;
  logic [CNT_W:0]           in_flight;
  logic [CNT_W:0]           credit_used;

`ifdef SRAM_REQ_ADAPTER_INIT_EN
  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (&init_addr_q) state_d = ST_RUN;
    end
  end

  assign run         = (state_q == ST_RUN);
  // The zero-fill strobe must stay quiet while reset is held, even though the FSM sits in INIT.
  assign init_wr     = (state_q == ST_INIT) && i_rst_n;
  assign init_addr   = init_addr_q;
  assign o_init_done = run;
`else
  logic live_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) live_q <= 1'b0;
    else          live_q <= 1'b1;
  end

  assign run         = live_q;
  assign init_wr     = 1'b0;
  assign init_addr   = '0;
  assign o_init_done = i_rst_n;
`endif

  assign req_fire = i_req_valid && o_req_ready;
  assign rsp_pop  = o_rsp_valid && i_rsp_ready;

  always_comb begin
    o_sram_write_enable = 1'b0;
    o_sram_address      = i_req_address;
    o_sram_write_data   = i_req_write_data;
    o_sram_byte_enable  = i_req_byte_enable;
    if (init_wr) begin
      o_sram_write_enable = 1'b1;
      o_sram_address      = init_addr;
      o_sram_write_data   = '0;
      o_sram_byte_enable  = '1;
    end else if (req_fire && i_req_write) begin
      o_sram_write_enable = 1'b1;
    end
  end

  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = req_fire && !i_req_write;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_pipe_q <= '0;
    else          rd_pipe_q <= rd_pipe_d;
  end

  // NOTE: blocking assignment is intended here; the loop accumulates a running sum within one evaluation.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + (CNT_W+1)'(rd_pipe_q[i]);
    end
    credit_used = in_flight + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(rsp_pop);
  end

  // A pop in the same cycle hands its slot straight back, which is what sustains one read per cycle.
  assign o_req_ready = run && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (rd_pipe_q[READ_LATENCY-1]),
    .i_push_data (i_sram_read_data),
    .i_pop       (rsp_pop),
    .o_pop_data  (o_rsp_read_data),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  assign o_rsp_valid = !fifo_empty;

endmodule

// File: tb/tb_sram_req_adapter.sv
// Self-checking bench for sram_req_adapter: SRAM model, scoreboard model, directed and random traffic.
// Define SRAM_REQ_ADAPTER_INIT_EN for both bench and RTL to exercise the zero-fill build.
module tb_sram_req_adapter;

  localparam int DW      = 128;
  localparam int AW      = 7;
  localparam int RL      = 2;
  localparam int BW      = DW / 8;
  localparam int WORDS   = 1 << AW;
  localparam int CREDITS = RL + 1;
`ifdef SRAM_REQ_ADAPTER_INIT_EN
  localparam int INIT_CYCLES = WORDS;
`else
  localparam int INIT_CYCLES = 0;
`endif
  localparam int RUN_START = (INIT_CYCLES > 0) ? INIT_CYCLES : 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_write = 1'b0;
  logic [AW-1:0] i_req_address = '0;
  logic [DW-1:0] i_req_write_data = '0;
  logic [BW-1:0] i_req_byte_enable = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b1;
  logic [DW-1:0] o_rsp_read_data;
  logic          o_sram_write_enable;
  logic [AW-1:0] o_sram_address;
  logic [DW-1:0] o_sram_write_data;
  logic [BW-1:0] o_sram_byte_enable;
  logic [DW-1:0] i_sram_read_data;
  logic          o_init_done;

  sram_req_adapter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .READ_LATENCY  (RL)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_req_valid         (i_req_valid),
    .o_req_ready         (o_req_ready),
    .i_req_write         (i_req_write),
    .i_req_address       (i_req_address),
    .i_req_write_data    (i_req_write_data),
    .i_req_byte_enable   (i_req_byte_enable),
    .o_rsp_valid         (o_rsp_valid),
    .i_rsp_ready         (i_rsp_ready),
    .o_rsp_read_data     (o_rsp_read_data),
    .o_sram_write_enable (o_sram_write_enable),
    .o_sram_address      (o_sram_address),
    .o_sram_write_data   (o_sram_write_data),
    .o_sram_byte_enable  (o_sram_byte_enable),
    .i_sram_read_data    (i_sram_read_data),
    .o_init_done         (o_init_done)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Two-cycle synchronous SRAM: address registered, then registered read data.
  logic [DW-1:0] mem [WORDS];
  logic [AW-1:0] sram_raddr_q;
  logic [DW-1:0] sram_rdata_q;

  always @(posedge i_clk) begin
    if (o_sram_write_enable) begin
      for (int b = 0; b < BW; b++) begin
        if (o_sram_byte_enable[b]) mem[o_sram_address][b*8 +: 8] <= o_sram_write_data[b*8 +: 8];
      end
    end
    sram_raddr_q <= o_sram_address;
    sram_rdata_q <= mem[sram_raddr_q];
  end
  assign i_sram_read_data = sram_rdata_q;

  // Behavioural model: shadow memory plus a queue of owed responses, each with its earliest cycle.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] shadow [WORDS];
  rsp_t          exp_q [$];
  int            pop_cycles [$];
  logic [DW-1:0] pop_data [$];
  int            cyc = 0;
  int            since_rel = 0;
  bit            exp_valid, exp_ready, pop, fire, in_init;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      check("rst_req_ready", DW'(o_req_ready), '0);
      check("rst_rsp_valid", DW'(o_rsp_valid), '0);
      check("rst_sram_we", DW'(o_sram_write_enable), '0);
      check("rst_init_done", DW'(o_init_done), '0);
      exp_q.delete();
      since_rel = 0;
    end else begin
      in_init   = since_rel < INIT_CYCLES;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      pop       = exp_valid && i_rsp_ready;
      // Outstanding reads minus a same-cycle pop must stay below the credit limit.
      exp_ready = (since_rel >= RUN_START) && ((exp_q.size() - int'(pop)) < CREDITS);
      fire      = i_req_valid && exp_ready;
      check("req_ready", DW'(o_req_ready), DW'(exp_ready));
      check("rsp_valid", DW'(o_rsp_valid), DW'(exp_valid));
      if (exp_valid) check("rsp_data", o_rsp_read_data, exp_q[0].data);
      check("init_done", DW'(o_init_done), DW'(!in_init));
      if (in_init) begin
        check("init_we", DW'(o_sram_write_enable), DW'(1'b1));
        check("init_addr", DW'(o_sram_address), DW'(since_rel));
        check("init_data", o_sram_write_data, '0);
        check("init_be", DW'(o_sram_byte_enable), DW'({BW{1'b1}}));
        shadow[since_rel] = '0;
      end else begin
        check("sram_we", DW'(o_sram_write_enable), DW'(fire && i_req_write));
        if (fire) check("sram_addr", DW'(o_sram_address), DW'(i_req_address));
        if (fire && i_req_write) begin
          check("sram_wdata", o_sram_write_data, i_req_write_data);
          check("sram_be", DW'(o_sram_byte_enable), DW'(i_req_byte_enable));
          for (int b = 0; b < BW; b++) begin
            if (i_req_byte_enable[b]) shadow[i_req_address][b*8 +: 8] = i_req_write_data[b*8 +: 8];
          end
        end
        if (fire && !i_req_write) exp_q.push_back('{cyc + RL + 1, shadow[i_req_address]});
      end
      if (pop) begin
        pop_cycles.push_back(cyc);
        pop_data.push_back(exp_q[0].data);
        void'(exp_q.pop_front());
      end
      since_rel++;
    end
    cyc++;
  end

  // Drives one request from posedge+1 and returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, output int stalls);
    i_req_valid       = 1'b1;
    i_req_write       = wr;
    i_req_address     = a;
    i_req_write_data  = d;
    i_req_byte_enable = be;
    stalls = 0;
    forever begin
      @(negedge i_clk);
      if (o_req_ready) break;
      stalls++;
      if (stalls > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL issue_timeout: ready still 0 after %0d cycles, required 1", stalls);
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_init_done();
    int n = 0;
    while (!o_init_done && n <= 1000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("init_done_timeout", DW'(o_init_done), DW'(1'b1));
  endtask

  initial begin
    int            st, total_stalls, lat, acc, base, stray;
    logic [DW-1:0] d;
    logic [7:0]    kb;

    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (50) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    wait_init_done();

    for (int a = 0; a < WORDS; a++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(1'b1, AW'(a), d, {BW{1'b1}}, st);
    end

    // Partial write merges into a known word; read returns three cycles after its handshake.
    i_rsp_ready = 1'b1;
    issue(1'b1, AW'(3), {16{8'h11}}, {BW{1'b1}}, st);
    issue(1'b1, AW'(3), {16{8'hA5}}, BW'(16'h0001), st);
    issue(1'b0, AW'(3), '0, '0, st);
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_rsp_valid && lat < 20);
    check("read_latency", DW'(lat), DW'(3));
    check("byte0_merge", o_rsp_read_data, {{15{8'h11}}, 8'hA5});
    @(negedge i_clk);
    check("single_response", DW'(o_rsp_valid), '0);
    @(posedge i_clk);
    #1;

    for (int k = 0; k < 16; k++) begin
      kb = 8'(k);
      issue(1'b1, AW'(k), {16{kb}}, {BW{1'b1}}, st);
    end
    base = pop_cycles.size();
    total_stalls = 0;
    for (int k = 0; k < 16; k++) begin
      issue(1'b0, AW'(k), '0, '0, st);
      total_stalls += st;
    end
    repeat (6) @(negedge i_clk);
    #1;
    check("b2b_stalls", DW'(total_stalls), '0);
    check("b2b_count", DW'(pop_cycles.size() - base), DW'(16));
    for (int k = 0; k < 16 && base + k < pop_data.size(); k++) begin
      kb = 8'(k);
      check("b2b_data", pop_data[base + k], {16{kb}});
      if (k > 0) check("b2b_consecutive", DW'(pop_cycles[base + k] - pop_cycles[base + k - 1]), DW'(1));
    end

    // Backpressure: three reads fit in the credit window, then ready must drop.
    @(posedge i_clk);
    #1;
    i_rsp_ready   = 1'b0;
    i_req_valid   = 1'b1;
    i_req_write   = 1'b0;
    i_req_address = AW'(5);
    acc = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_req_ready) acc++;
    end
    check("credit_accepts", DW'(acc), DW'(3));
    check("credit_ready_low", DW'(o_req_ready), '0);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    base = pop_cycles.size();
    repeat (4) @(negedge i_clk);
    #1;
    check("credit_drain_count", DW'(pop_cycles.size() - base), DW'(3));
    check("credit_ready_back", DW'(o_req_ready), DW'(1'b1));

    // Reset with two reads in flight must discard them.
    @(posedge i_clk);
    #1;
    issue(1'b0, AW'(7), '0, '0, st);
    issue(1'b0, AW'(8), '0, '0, st);
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_rsp_valid) stray++;
    end
    check("no_stray_rsp", DW'(stray), '0);
    wait_init_done();

    for (int n = 0; n < 3000; n++) begin
      @(posedge i_clk);
      #1;
      i_req_valid       = ($urandom_range(3) != 0);
      i_req_write       = $urandom_range(1) == 1;
      i_req_address     = AW'($urandom_range(15));
      i_req_write_data  = {$urandom, $urandom, $urandom, $urandom};
      i_req_byte_enable = BW'($urandom);
      i_rsp_ready       = ($urandom_range(3) != 0);
    end
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (12) @(negedge i_clk);
    check("drain_rsp_valid", DW'(o_rsp_valid), '0);
    check("drain_req_ready", DW'(o_req_ready), DW'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
